// File: rtl/bcd_prescaled_counter_if.sv
// Bundle of control inputs and display/status outputs for bcd_prescaled_counter.
// master drives the controls and observes the outputs; slave is the counter.
interface bcd_prescaled_counter_if #(
    parameter int DIGITS = 4
);
    // Level controls, no handshake: en/down/clr/load/load_val are sampled on
    // every rising CLOCK_50 edge; tick/wrap are single-cycle registered pulses.
    logic                  en;
    logic                  down;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  tick;
    logic                  wrap;

    modport master (
        output en, down, clr, load, load_val,
        input  bcd, seg, tick, wrap
    );

    modport slave (
        input  en, down, clr, load, load_val,
        output bcd, seg, tick, wrap
    );
endinterface

// File: rtl/bcd_prescaled_counter.sv
// Prescaled packed-BCD up/down counter with active-low seven-segment outputs.
// Define BCD_COUNTER_BLANK_EN to blank leading-zero digits on seg.
module bcd_prescaled_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000000,
    parameter int PS_W     = 20
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    bcd_prescaled_counter_if.slave   bus
);

`ifdef BCD_COUNTER_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]       ps_q, ps_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;

    logic [4*DIGITS-1:0]   step_val;
    logic [4*DIGITS-1:0]   load_sat;
    logic [7*DIGITS-1:0]   seg_w;
    logic                  step;
    logic                  carry;
    logic                  lead;
    logic [3:0]            dig;
    logic [3:0]            lv;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Ripple carry/borrow across digits; carry left over means every digit rolled.
    always_comb begin
        step_val = bcd_q;
        load_sat = '0;
        carry    = 1'b1;
        dig      = '0;
        lv       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (carry) begin
                if (!bus.down) begin
                    if (dig >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            lv = bus.load_val[4*i +: 4];
            load_sat[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
        end
    end

    always_comb begin
        step   = bus.en && (ps_q == PS_LAST);
        ps_d   = ps_q;
        bcd_d  = bcd_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.clr) begin
            ps_d  = '0;
            bcd_d = '0;
        end else if (bus.load) begin
            ps_d  = '0;
            bcd_d = load_sat;
        end else if (bus.en) begin
            if (step) begin
                ps_d   = '0;
                bcd_d  = step_val;
                tick_d = 1'b1;
                wrap_d = carry;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ps_q   <= '0;
            bcd_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            bcd_q  <= bcd_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    // Scan from the top digit; digit 0 is always lit so zero shows as "0".
    always_comb begin
        seg_w = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
            if (BLANK_EN && lead && (i != 0)) seg_w[7*i +: 7] = 7'h7F;
            else seg_w[7*i +: 7] = seg_decode(bcd_q[4*i +: 4]);
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.seg  = seg_w;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_prescaled_counter.sv
// Directed table-driven bench for bcd_prescaled_counter (DIGITS=4, PRESCALE=4).
module tb_bcd_prescaled_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_prescaled_counter_if #(.DIGITS(4)) bus ();

    bcd_prescaled_counter #(
        .DIGITS   (4),
        .PRESCALE (4),
        .PS_W     (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] lval;
        logic        en;
        logic        down;
        int          cycles;
        logic [15:0] exp_bcd;
        logic        exp_tick;
        logic        exp_wrap;
        logic [6:0]  exp_seg0;
    } vec_t;

    vec_t vecs[$];

    // scoreboard: expected values queued, then popped against observed ones
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        exp_q.push_back(exp);
        check(name, act);
    endtask

    task automatic add_vec(input logic clr, input logic load, input logic [15:0] lval,
                           input logic en, input logic down, input int cycles,
                           input logic [15:0] eb, input logic et, input logic ew,
                           input logic [6:0] es);
        vec_t v;
        v.clr = clr; v.load = load; v.lval = lval; v.en = en; v.down = down;
        v.cycles = cycles; v.exp_bcd = eb; v.exp_tick = et; v.exp_wrap = ew;
        v.exp_seg0 = es;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic load, input logic [15:0] lval,
                         input logic en, input logic down);
        bus.clr = clr; bus.load = load; bus.load_val = lval; bus.en = en; bus.down = down;
    endtask

    logic [27:0] seg_0042;
    logic [27:0] seg_0000;
    logic [27:0] seg_reset;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef BCD_COUNTER_BLANK_EN
        seg_0042  = {7'h7F, 7'h7F, 7'b0011001, 7'b0100100};
        seg_0000  = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
`else
        seg_0042  = {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100};
        seg_0000  = {4{7'b1000000}};
`endif
        seg_reset = seg_0000;

        //      clr   load  lval      en    down  cyc bcd       tick  wrap  seg0
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0000, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 7'h79);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 7'h79);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0002, 1'b1, 1'b0, 7'h24);
        add_vec(1'b0, 1'b1, 16'h9998, 1'b1, 1'b0, 1, 16'h9998, 1'b0, 1'b0, 7'h00);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 16'h9999, 1'b1, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h9999, 1'b0, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 7'h40);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 1, 16'h0100, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4, 16'h0099, 1'b1, 1'b0, 7'h10);
        add_vec(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4, 16'h9999, 1'b1, 1'b1, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h9999, 1'b0, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 10, 16'h9999, 1'b0, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2, 16'h9999, 1'b0, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h9998, 1'b1, 1'b0, 7'h00);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h9998, 1'b0, 1'b0, 7'h00);
        add_vec(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1, 16'h1234, 1'b0, 1'b0, 7'h19);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h1234, 1'b0, 1'b0, 7'h19);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h1235, 1'b1, 1'b0, 7'h12);
        add_vec(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b1, 16'hAB3C, 1'b0, 1'b0, 1, 16'h9939, 1'b0, 1'b0, 7'h10);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 7'h40);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 16'h0001, 1'b1, 1'b0, 7'h79);
        add_vec(1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, 1, 16'h0099, 1'b0, 1'b0, 7'h10);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 16'h0100, 1'b1, 1'b0, 7'h40);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        expect_val("reset_bcd",  32'(bus.bcd),  32'h0000);
        expect_val("reset_tick", 32'(bus.tick), 32'd0);
        expect_val("reset_wrap", 32'(bus.wrap), 32'd0);
        expect_val("reset_seg",  32'(bus.seg),  32'(seg_reset));
        rst_n = 1'b1;

        // table
        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].clr, vecs[v].load, vecs[v].lval, vecs[v].en, vecs[v].down);
            for (int c = 0; c < vecs[v].cycles; c++) begin
                @(posedge clk);
                #1;
                if (c < vecs[v].cycles - 1)
                    expect_val($sformatf("v%0d_mid_tick", v), 32'(bus.tick), 32'd0);
            end
            expect_val($sformatf("v%0d_bcd", v),  32'(bus.bcd),      32'(vecs[v].exp_bcd));
            expect_val($sformatf("v%0d_tick", v), 32'(bus.tick),     32'(vecs[v].exp_tick));
            expect_val($sformatf("v%0d_wrap", v), 32'(bus.wrap),     32'(vecs[v].exp_wrap));
            expect_val($sformatf("v%0d_seg0", v), 32'(bus.seg[6:0]), 32'(vecs[v].exp_seg0));
        end

        // async reset while tick is high (last vector ends on a step)
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_val("pre_areset_tick", 32'(bus.tick), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("areset_bcd",  32'(bus.bcd),  32'h0000);
        expect_val("areset_tick", 32'(bus.tick), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            expect_val($sformatf("post_reset_c%0d_tick", c), 32'(bus.tick), 32'd0);
        end
        @(posedge clk);
        #1;
        expect_val("post_reset_first_tick", 32'(bus.tick), 32'd1);
        expect_val("post_reset_bcd",        32'(bus.bcd),  32'h0001);

        // full-display checks (leading-zero behaviour depends on build)
        drive(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_val("seg_0042", 32'(bus.seg), 32'(seg_0042));
        expect_val("bcd_0042", 32'(bus.bcd), 32'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_val("seg_0000", 32'(bus.seg), 32'(seg_0000));
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_prescaled_counter.md
Name: bcd_prescaled_counter

Overview:
- Multi-digit decimal up/down counter advanced by an internal clock prescaler, driving one seven-segment display per digit.
- Value is held natively as packed BCD with per-digit carry/borrow, so no binary-to-BCD converter is needed.
- Adds enable, direction, clear, parallel load and wrap indication.
- Sits at board top level between CLOCK_50 and the HEX displays; reused for timers, stopwatches and event counters.

Parameters:
- DIGITS, 4: number of decimal digits, legal range 1..8.
- PRESCALE, 1000000: CLOCK_50 cycles per count step, minimum 1. PRESCALE=1 steps every enabled cycle.
- PS_W, 20: prescaler register width. Must satisfy 2^PS_W >= PRESCALE.

Ports:
- CLOCK_50  in  1  system clock; all state is updated on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, the prescaler and value are frozen.
- down  in  1  direction: 0 = up, 1 = down. Sampled on the tick cycle.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD load value; digit 0 is bits [3:0].
- bcd  out  4*DIGITS  current value, packed BCD, registered.
- seg  out  7*DIGITS  segments, active-low, per digit {g,f,e,d,c,b,a}; digit 0 is bits [6:0].
- tick  out  1  one-cycle pulse on each cycle in which a count step occurs.
- wrap  out  1  one-cycle pulse on the cycle a step crosses 0/max.

Behaviour:
- Reset (asynchronous, RESET_N=0): prescaler=0, bcd=0, tick=0, wrap=0. seg then shows "0" on every digit (7'b1000000 per digit).
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - On the cycle it equals PRESCALE-1, it returns to 0 and a step is taken.
  - The first step after reset occurs PRESCALE enabled cycles after reset release.
- Step, up:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All-9s wraps to all-0s and asserts wrap.
- Step, down:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All-0s wraps to all-9s and asserts wrap.
- tick and wrap are registered; each is high for exactly the one cycle after the step edge, concurrent with the new bcd value.
- Priority per cycle: clr > load > step.
  - clr: bcd=0, prescaler=0, no tick, no wrap. Applies even when en=0.
  - load: bcd=load_val, prescaler=0, no tick, no wrap. Applies even when en=0. Any load digit >9 is stored as 9 (per-digit saturation).
  - A step that coincides with clr or load is discarded.
- en=0: prescaler holds its value and no steps occur. When en returns to 1, counting resumes from the held prescaler value.
- A change on down takes effect at the next step; the prescaler phase is unaffected.
- bcd digits are always in 0..9; no illegal digit is ever produced.
- seg is combinational from the bcd register via a standard 0-9 decoder. Any code >9 decodes to all-off (7'h7F), which is unreachable in normal operation.
- Reset asserted mid-count: all state clears immediately (asynchronously). Any in-flight tick or wrap pulse is killed.

Optional Feature:
- Macro: BCD_COUNTER_BLANK_EN.
- Defined:
  - Leading-zero blanking: any digit above the most significant non-zero digit drives seg=7'h7F.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - bcd output is unaffected.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan:
- Parameters DIGITS=4, PRESCALE=4; reset, then en=1, down=0 -> tick on every 4th cycle; bcd reads 0001, 0002, ... after successive ticks; seg[6:0]=7'b1111001 when bcd=0001.
- Load 9998 with en=1 and up, run 2 steps -> bcd=9999, then 0000 with wrap=1 for exactly one cycle; tick=1 on the same cycle.
- Load 0100, down=1, run 1 step -> bcd=0099 (two borrows). Load 0000, 1 step -> bcd=9999 with wrap=1.
- Drop en for 10 cycles mid-prescale -> bcd and prescaler frozen; the step lands at the remaining prescaler count after en returns. Assert clr and load together -> bcd=0000. Load 0xAB3C -> bcd=9939.
- Assert RESET_N=0 asynchronously between clock edges while tick=1 -> bcd=0 and tick=0 immediately; the first tick after release comes 4 cycles later.
- With BCD_COUNTER_BLANK_EN defined, load 0042 -> seg digits 3 and 2 = 7'h7F, digit 1 shows "4", digit 0 shows "2". Load 0000 -> only digit 0 lit, showing "0".
